adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Shares one instance of the existing parameterized `adder` (inputs a, b; output y; WIDTH bits) between NREQ requesters.
- Round-robin arbitration.
- Valid/ready handshake on each request port.
- Single registered response channel tagged with the requester id.
- Sits between datapath units that need occasional additions (e.g. PC/branch-target helpers, address generators) and one physical adder, trading area for latency.

Parameters:
- WIDTH, 32, operand and result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester id (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept (one-hot or zero).
- req_a  input  NREQ*WIDTH  flattened operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  flattened operand B, same packing.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  IDW  index of requester that produced rsp_y.
- rsp_y  output  WIDTH  sum (a+b) modulo 2^WIDTH.

Behaviour:
- State: EMPTY (rsp_valid=0) / FULL (rsp_valid=1); single response register.
- Reset, synchronous: rsp_valid=0, rsp_id=0, rsp_y=0, rr pointer=0. req_ready=0 during the reset cycle.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Grant:
  - When can_accept, req_ready has exactly one bit set: the first requester with req_valid=1, searching from rr pointer upward with wrap-around NREQ-1 -> 0.
  - Otherwise req_ready = 0.
  - req_ready never asserts for a requester whose req_valid=0.
- Transfer occurs when req_valid[i] && req_ready[i].
- On a transfer from requester g:
  - The adder is driven with req_a/req_b slice g.
  - Next cycle: rsp_y = y, rsp_id = g, rsp_valid = 1.
  - rr pointer = (g+1) mod NREQ.
- Latency: one cycle from accept to rsp_valid.
- Throughput: one result per cycle while rsp_ready stays high.
- Response consumed (rsp_valid && rsp_ready) with no new transfer in the same cycle: rsp_valid -> 0; rsp_y and rsp_id hold their last values.
- Simultaneous consume and new accept: register is reloaded and rsp_valid stays 1, with no bubble.
- FULL and rsp_ready=0 (back-pressure):
  - All req_ready = 0.
  - rsp_y and rsp_id stable.
  - rr pointer unchanged.
- No valid requests: pointer unchanged, no state change.
- Arithmetic: carry out of bit WIDTH-1 discarded (wrap-around, e.g. 0xFFFFFFFF + 1 = 0).
- Requester contract: a requester holds a/b stable while req_valid is high; the block samples them only in the grant cycle.
- Reset mid-operation discards any pending response; no output is produced for it.
- Fairness: a continuously valid requester is granted within NREQ accept cycles.

Optional Feature:
- Macro: ADDER_SHARE_ARB_OVF_EN.
- Defined: extra output port rsp_ovf (1 bit), registered with rsp_y.
  - Set when a[WIDTH-1] == b[WIDTH-1] and y[WIDTH-1] != a[WIDTH-1] (signed two's-complement overflow).
  - Reset value 0.
- Undefined: port absent, no overflow logic.

Decomposition:
- Package adder_share_pkg:
  - Default WIDTH/NREQ constants.
  - Typedef for the response-state enum {RSP_EMPTY, RSP_FULL}.
  - Function next_rr(ptr, grant, nreq).
- Sub-module rr_arbiter (parameter NREQ), purely combinational:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant vector, encoded grant index, any_grant.
- Top instantiates rr_arbiter and the existing adder #(WIDTH).

Test Plan:
- Single request: reset, then req_valid=0001, a=5, b=7 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_y=12, rsp_id=0.
- Round-robin: all four valid continuously, rsp_ready=1, requester i a=i, b=100 -> grants 0,1,2,3,0 on consecutive cycles; rsp_y 100,101,102,103,100.
- Back-pressure: rsp_ready=0 after first result -> req_ready=0000, rsp_y held for 5 cycles; rsp_ready=1 then accepts next requester (pointer+1) in the same cycle.
- Wrap-around: a=0xFFFFFFFF, b=1 -> rsp_y=0. With ADDER_SHARE_ARB_OVF_EN, a=0x7FFFFFFF, b=1 -> rsp_y=0x80000000, rsp_ovf=1.
- Reset mid-operation: rsp_valid=1 and reset asserted one cycle -> next cycle rsp_valid=0, rsp_y=0, pointer=0; a following request from requester 2 is granted with rsp_id=2.
- Sparse requests: only requester 3 valid, pointer at 1 -> grant 3; pointer becomes 0; then requesters 0 and 3 both valid -> grant 0.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared constants, response-state type and round-robin pointer helper
// for the adder_share_arb block.
package adder_share_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_NREQ  = 4;

  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } rsp_state_t;

  // Pointer moves just past the granted requester; an out-of-range grant leaves it alone.
  function automatic int unsigned next_rr(input int unsigned ptr,
                                          input int unsigned grant,
                                          input int unsigned nreq);
    if (grant >= nreq) return ptr;
    return (grant + 1 >= nreq) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational WIDTH-bit adder; carry out is discarded.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping NREQ-1 -> 0, producing one-hot and encoded grants.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    if (en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        j = 32'(ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!any_grant && req[j]) begin
          any_grant = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one adder among NREQ valid/ready requesters with round-robin grant
// and a single registered, id-tagged response. Optional: ADDER_SHARE_ARB_OVF_EN.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned NREQ  = DEFAULT_NREQ,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y
`ifdef ADDER_SHARE_ARB_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  rsp_state_t        state;
  logic [IDW-1:0]    rr_ptr;
  logic              can_accept;
  logic              any_grant;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic [WIDTH-1:0]  sum;

  assign rsp_valid  = (state == RSP_FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign req_ready  = grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (can_accept && !reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // One-hot grant makes an OR-mux sufficient for operand selection.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | req_a[i*WIDTH +: WIDTH];
        b_sel = b_sel | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a (a_sel),
    .b (b_sel),
    .y (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RSP_EMPTY;
      rsp_id <= '0;
      rsp_y  <= '0;
      rr_ptr <= '0;
`ifdef ADDER_SHARE_ARB_OVF_EN
      rsp_ovf <= 1'b0;
`endif
    end else if (any_grant) begin
      state  <= RSP_FULL;
      rsp_id <= grant_idx;
      rsp_y  <= sum;
      rr_ptr <= IDW'(next_rr(32'(rr_ptr), 32'(grant_idx), NREQ));
`ifdef ADDER_SHARE_ARB_OVF_EN
      rsp_ovf <= (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
`endif
    end else if (rsp_ready) begin
      state <= RSP_EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed scenarios then random
// traffic, compared against a transaction-level reference model.
module tb_adder_share_arb;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = $clog2(NREQ);

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_y;
`ifdef ADDER_SHARE_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  adder_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
`ifdef ADDER_SHARE_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] opa [NREQ];
  logic [WIDTH-1:0] opb [NREQ];

  // Reference model state: response register contents and next-search pointer.
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_y     = '0;
  int               m_id    = 0;
  int               m_ptr   = 0;
  logic             m_ovf   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic rst);
    logic [NREQ-1:0] exp_g;
    int              g;
    int              idx;
    longint          s;
    req_valid = v;
    rsp_ready = rr;
    reset     = rst;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = opa[i];
      req_b[i*WIDTH +: WIDTH] = opb[i];
    end
    #1;
    exp_g = '0;
    g     = -1;
    if (!rst && (!m_valid || rr)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_g[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_g));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_y = '0; m_id = 0; m_ptr = 0; m_ovf = 1'b0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_y     = WIDTH'((64'(opa[g]) + 64'(opb[g])) % (64'd1 << WIDTH));
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
      s       = longint'($signed(opa[g])) + longint'($signed(opb[g]));
      m_ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (rr) begin
      m_valid = 1'b0;
    end
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_y", 64'(rsp_y), 64'(m_y));
    check("rsp_id", 64'(rsp_id), 64'(m_id));
`ifdef ADDER_SHARE_ARB_OVF_EN
    check("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
`endif
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check("reset_valid_const", 64'(rsp_valid), 64'd0);

    // Single request: 5 + 7 from requester 0
    opa[0] = 32'd5; opb[0] = 32'd7;
    step(4'b0001, 1'b1, 1'b0);
    check("single_y_const", 64'(rsp_y), 64'd12);
    step(4'b0000, 1'b1, 1'b0);

    // Round-robin from pointer 0 with everyone valid
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) begin opa[i] = WIDTH'(i); opb[i] = 32'd100; end
    for (int n = 0; n < 5; n++) step(4'b1111, 1'b1, 1'b0);
    check("rr_fifth_id_const", 64'(rsp_id), 64'd0);

    // Back-pressure: response held, nothing granted, then resume at pointer
    for (int n = 0; n < 5; n++) step(4'b1111, 1'b0, 1'b0);
    check("bp_hold_y_const", 64'(rsp_y), 64'd100);
    step(4'b1111, 1'b1, 1'b0);
    check("bp_resume_id_const", 64'(rsp_id), 64'd1);

    // Wrap-around arithmetic
    step(4'b0000, 1'b0, 1'b1);
    opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd1;
    step(4'b0001, 1'b1, 1'b0);
    check("wrap_y_const", 64'(rsp_y), 64'd0);
    opa[1] = 32'h7FFF_FFFF; opb[1] = 32'd1;
    step(4'b0010, 1'b1, 1'b0);
    check("ovf_y_const", 64'(rsp_y), 64'h8000_0000);

    // Reset mid-operation with a pending response
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    opa[2] = 32'd40; opb[2] = 32'd2;
    step(4'b0100, 1'b1, 1'b0);
    check("post_reset_id_const", 64'(rsp_id), 64'd2);

    // Sparse requests: pointer at 1, only 3 valid; then 0 and 3 valid
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    check("sparse_id3_const", 64'(rsp_id), 64'd3);
    step(4'b1001, 1'b1, 1'b0);
    check("sparse_id0_const", 64'(rsp_id), 64'd0);

    // Random traffic with occasional back-pressure and reset
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 7))
          0:       begin opa[i] = 32'hFFFF_FFFF; opb[i] = $urandom; end
          1:       begin opa[i] = 32'h7FFF_FFFF; opb[i] = $urandom_range(0, 3); end
          2:       begin opa[i] = 32'h8000_0000; opb[i] = 32'h8000_0000 | $urandom; end
          default: begin opa[i] = $urandom; opb[i] = $urandom; end
        endcase
      end
      step(NREQ'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
